pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 The block SHALL have parameter SERVE_FRAMES, default 60, number of frame_tick pulses the ball is held before play.
REQ-002 The block SHALL have parameter MISS_FRAMES, default 30, number of frame_tick pulses of pause after a miss.
REQ-003 The block SHALL have parameter LIVES, default 3, lives loaded at game start, range 1-3.
REQ-004 clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 frame_tick  input  1  one-clk pulse per video frame.
REQ-007 start  input  1  player start button, level, already synchronous to clk.
REQ-008 hit  input  1  one-clk pulse, ball bounced off paddle.
REQ-009 miss  input  1  one-clk pulse, ball passed paddle into bottom border.
REQ-010 ball_run  output  1  enables per-frame ball position update.
REQ-011 ball_load  output  1  one-clk pulse, reload ball to serve position.
REQ-012 score  output  8  binary points in current game.
REQ-013 lives  output  2  remaining lives.
REQ-014 state  output  3  current FSM state encoding.
REQ-015 game_over  output  1  high while in OVER.
REQ-016 speed  output  2  ball speed level for the ball datapath.

Function
REQ-017 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4; encodings 5-7 SHALL return to IDLE on the next clock.
REQ-018 start SHALL be registered each clock into start_q; start_pe = start AND NOT start_q; a level held high SHALL produce exactly one start_pe.
REQ-019 IDLE or OVER with start_pe SHALL go to SERVE on the same edge, loading score=0, lives=LIVES, speed=0.
REQ-020 ball_load SHALL be high exactly during the first clock in which state==SERVE, every SERVE entry.
REQ-021 An 8-bit frame counter SHALL clear on every state entry and increment on frame_tick in SERVE and MISS.
REQ-022 SERVE SHALL go to PLAY on the frame_tick at which the counter equals SERVE_FRAMES-1.
REQ-023 ball_run SHALL be high if and only if state==PLAY.
REQ-024 PLAY with hit SHALL increment score by 1 on that edge, saturating at 255.
REQ-025 PLAY with miss SHALL go to MISS and decrement lives by 1 on that edge; lives SHALL not go below 0.
REQ-026 hit and miss in the same PLAY cycle: miss SHALL win; score SHALL be unchanged.
REQ-027 MISS SHALL leave on the frame_tick at which the counter equals MISS_FRAMES-1: to OVER if lives==0, else to SERVE.
REQ-028 hit, miss and start SHALL be ignored in states where not named above; score and lives SHALL hold in OVER until the next start_pe.
REQ-029 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-030 While rst is low, state SHALL be IDLE and start_q, frame counter, score, lives, speed, ball_load, ball_run and game_over SHALL all be 0, independent of clk.
REQ-031 Reset asserted mid-PLAY SHALL discard score and lives immediately; after release, the block SHALL wait in IDLE for start_pe.

Configuration
REQ-032 With macro PONG_SPEEDUP_EN defined, a 3-bit hit counter SHALL count accepted hits per game; each wrap from 7 to 0 SHALL increment speed, saturating at 3; hit counter and speed SHALL clear at game start.
REQ-033 Without PONG_SPEEDUP_EN, speed SHALL be constant 0 and the hit counter SHALL not be built.

Verification
Benches use SERVE_FRAMES=4, MISS_FRAMES=2, LIVES=3.
REQ-034 Hold rst low, toggle start and hit -> state=0, score=0, lives=0, all 1-bit outputs 0.
REQ-035 Start held high 10 clocks -> single SERVE entry, ball_load high 1 clock, lives=3; 4th frame_tick -> state=2, ball_run=1.
REQ-036 In PLAY, 5 hit pulses then hit and miss in the same cycle -> score=5, lives=2, state=3; 2 frame_ticks later -> state=1 with one ball_load pulse.
REQ-037 Three misses with serves between -> after 3rd MISS pause state=4, game_over=1, score held; start_pe -> score=0, lives=3, state=1.
REQ-038 300 hits -> score saturates at 255; with PONG_SPEEDUP_EN, speed=1 after 8 hits, 3 after 24 and stays 3; without the macro, speed=0 throughout.
REQ-039 rst pulsed low mid-PLAY with score=7 -> immediate state=0, score=0, ball_run=0; no ball_load until the next start_pe.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Pong game controller signal bundle.
// master drives game events, slave is the controller.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic       miss;
  logic       ball_run;
  logic       ball_load;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       game_over;
  logic [1:0] speed;

  modport master (
    output frame_tick, start, hit, miss,
    input  ball_run, ball_load, score, lives,
    input  state, game_over, speed
  );

  modport slave (
    input  frame_tick, start, hit, miss,
    output ball_run, ball_load, score, lives,
    output state, game_over, speed
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: serve, play, miss pause, game over.
// Optional PONG_SPEEDUP_EN raises speed every 8 accepted hits.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int LIVES        = 3
) (
  input  logic            clk,
  input  logic            rst,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       start_q;
  logic       start_pe;
  logic       serve_done;
  logic       miss_done;
  logic       hit_ok;
  logic       game_start;
  logic       ball_load_q;
  logic [7:0] frame_cnt;
  logic [7:0] score_q;
  logic [1:0] lives_q;

  assign start_pe   = bus.start & ~start_q;
  assign serve_done = bus.frame_tick &&
                      (frame_cnt == 8'(SERVE_FRAMES - 1));
  assign miss_done  = bus.frame_tick &&
                      (frame_cnt == 8'(MISS_FRAMES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = IDLE;
    game_start = 1'b0;
    hit_ok     = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        state_d = state_q;
        if (start_pe) begin
          state_d    = SERVE;
          game_start = 1'b1;
        end
      end
      SERVE: state_d = serve_done ? PLAY : SERVE;
      PLAY: begin
        // a simultaneous miss swallows the hit
        if (bus.miss) begin
          state_d = MISS;
        end else begin
          state_d = PLAY;
          hit_ok  = bus.hit;
        end
      end
      MISS: begin
        state_d = MISS;
        if (miss_done)
          state_d = (lives_q == 2'd0) ? OVER : SERVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q     <= 1'b0;
      ball_load_q <= 1'b0;
      frame_cnt   <= 8'd0;
      score_q     <= 8'd0;
      lives_q     <= 2'd0;
    end else begin
      start_q     <= bus.start;
      ball_load_q <= (state_d == SERVE) &&
                     (state_q != SERVE);
      if (state_d != state_q)
        frame_cnt <= 8'd0;
      else if (bus.frame_tick &&
               (state_q == SERVE || state_q == MISS))
        frame_cnt <= frame_cnt + 8'd1;
      if (game_start) begin
        score_q <= 8'd0;
        lives_q <= 2'(LIVES);
      end else begin
        if (hit_ok && score_q != 8'hff)
          score_q <= score_q + 8'd1;
        if (state_q == PLAY && bus.miss &&
            lives_q != 2'd0)
          lives_q <= lives_q - 2'd1;
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [2:0] hit_cnt;
  logic [1:0] speed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= 3'd0;
      speed_q <= 2'd0;
    end else if (game_start) begin
      hit_cnt <= 3'd0;
      speed_q <= 2'd0;
    end else if (hit_ok) begin
      hit_cnt <= hit_cnt + 3'd1;
      if (hit_cnt == 3'd7 && speed_q != 2'd3)
        speed_q <= speed_q + 2'd1;
    end
  end

  assign bus.speed = speed_q;
`else
  assign bus.speed = 2'd0;
`endif

  assign bus.ball_run  = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);
  assign bus.ball_load = ball_load_q;
  assign bus.state     = state_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed plus randomized bench for pong_game_ctrl.
// Expected values come from a game-level score/lives model.
module tb_pong_game_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_score;
  int   exp_lives;
  int   n_load;
  int   n_entry;
  int   k;
  logic [2:0] prev_state;

  pong_game_ctrl_if pif ();

  pong_game_ctrl #(
    .SERVE_FRAMES(4),
    .MISS_FRAMES (2),
    .LIVES       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_speed(int h);
`ifdef PONG_SPEEDUP_EN
    return (h / 8 > 3) ? 3 : h / 8;
`else
    return h * 0;
`endif
  endfunction

  function automatic int sat255(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    idle($urandom_range(0, 2));
    pif.frame_tick = 1'b1;
    @(negedge clk);
    pif.frame_tick = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic pulse_hit();
    idle($urandom_range(0, 1));
    pif.hit = 1'b1;
    @(negedge clk);
    pif.hit = 1'b0;
  endtask

  task automatic pulse_miss();
    idle($urandom_range(0, 1));
    pif.miss = 1'b1;
    @(negedge clk);
    pif.miss = 1'b0;
  endtask

  task automatic press_start();
    pif.start = 1'b1;
    @(negedge clk);
    pif.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    pif.frame_tick = 1'b0;
    pif.start = 1'b0;
    pif.hit = 1'b0;
    pif.miss = 1'b0;

    // inputs toggling while held in reset
    repeat (6) begin
      @(negedge clk);
      pif.start = ~pif.start;
      pif.hit   = ~pif.hit;
    end
    @(negedge clk);
    chk("rst_state", 32'(pif.state), 0);
    chk("rst_score", 32'(pif.score), 0);
    chk("rst_lives", 32'(pif.lives), 0);
    chk("rst_run", 32'(pif.ball_run), 0);
    chk("rst_load", 32'(pif.ball_load), 0);
    chk("rst_over", 32'(pif.game_over), 0);
    chk("rst_speed", 32'(pif.speed), 0);
    pif.start = 1'b0;
    pif.hit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    chk("idle_state", 32'(pif.state), 0);

    // start held high for 10 clocks
    n_load = 0;
    n_entry = 0;
    prev_state = pif.state;
    pif.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pif.ball_load === 1'b1) n_load++;
      if (pif.state == 3'd1 && prev_state != 3'd1)
        n_entry++;
      prev_state = pif.state;
    end
    pif.start = 1'b0;
    chk("start_entries", 32'(n_entry), 1);
    chk("start_loads", 32'(n_load), 1);
    chk("start_lives", 32'(pif.lives), 3);
    chk("start_score", 32'(pif.score), 0);
    exp_score = 0;
    exp_lives = 3;

    ticks(3);
    chk("serve_3tick", 32'(pif.state), 1);
    chk("serve_run0", 32'(pif.ball_run), 0);
    tick();
    chk("play_state", 32'(pif.state), 2);
    chk("play_run", 32'(pif.ball_run), 1);

    repeat (5) begin
      pulse_hit();
      exp_score++;
    end
    chk("five_hits", 32'(pif.score), 5);
    pif.hit = 1'b1;
    pif.miss = 1'b1;
    @(negedge clk);
    pif.hit = 1'b0;
    pif.miss = 1'b0;
    exp_lives--;
    chk("hm_score", 32'(pif.score), 5);
    chk("hm_lives", 32'(pif.lives), 2);
    chk("hm_state", 32'(pif.state), 3);
    tick();
    chk("miss_1tick", 32'(pif.state), 3);
    tick();
    chk("reserve_state", 32'(pif.state), 1);
    chk("reserve_load", 32'(pif.ball_load), 1);
    @(negedge clk);
    chk("reserve_load_end", 32'(pif.ball_load), 0);

    // play out remaining lives with random hit counts
    while (exp_lives > 0) begin
      ticks(4);
      chk("loop_play", 32'(pif.state), 2);
      k = $urandom_range(0, 6);
      repeat (k) pulse_hit();
      exp_score = sat255(exp_score + k);
      pulse_miss();
      exp_lives--;
      chk("loop_lives", 32'(pif.lives), 32'(exp_lives));
      ticks(2);
      chk("loop_next", 32'(pif.state),
          (exp_lives == 0) ? 4 : 1);
      chk("loop_score", 32'(pif.score), 32'(exp_score));
    end
    chk("over_flag", 32'(pif.game_over), 1);
    pulse_hit();
    pulse_miss();
    ticks(3);
    chk("over_hold_st", 32'(pif.state), 4);
    chk("over_hold_sc", 32'(pif.score), 32'(exp_score));
    chk("over_hold_lv", 32'(pif.lives), 0);
    press_start();
    chk("restart_state", 32'(pif.state), 1);
    chk("restart_score", 32'(pif.score), 0);
    chk("restart_lives", 32'(pif.lives), 3);
    chk("restart_load", 32'(pif.ball_load), 1);

    // saturation and speed ramp
    ticks(4);
    chk("sat_play", 32'(pif.state), 2);
    for (int i = 1; i <= 300; i++) begin
      pulse_hit();
      if (i == 7 || i == 8 || i == 23 || i == 24 ||
          i == 255 || i == 256 || i == 300) begin
        chk("sat_score", 32'(pif.score), 32'(sat255(i)));
        chk("sat_speed", 32'(pif.speed),
            32'(exp_speed(i)));
      end
    end
    chk("sat_lives", 32'(pif.lives), 3);

    // asynchronous reset mid-play
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(pif.state), 0);
    chk("arst_score", 32'(pif.score), 0);
    chk("arst_speed", 32'(pif.speed), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    press_start();
    chk("g3_state", 32'(pif.state), 1);
    ticks(4);
    repeat (7) pulse_hit();
    chk("g3_score", 32'(pif.score), 7);
    chk("g3_run", 32'(pif.ball_run), 1);
    #3 rst = 1'b0;
    #1;
    chk("rst7_state", 32'(pif.state), 0);
    chk("rst7_score", 32'(pif.score), 0);
    chk("rst7_run", 32'(pif.ball_run), 0);
    chk("rst7_lives", 32'(pif.lives), 0);
    @(negedge clk);
    rst = 1'b1;
    n_load = 0;
    for (int i = 0; i < 20; i++) begin
      pif.frame_tick = 1'($urandom_range(0, 1));
      pif.hit = 1'($urandom_range(0, 1));
      pif.miss = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pif.ball_load !== 1'b0) n_load++;
    end
    pif.frame_tick = 1'b0;
    pif.hit = 1'b0;
    pif.miss = 1'b0;
    chk("post_rst_load", 32'(n_load), 0);
    chk("post_rst_state", 32'(pif.state), 0);
    press_start();
    chk("post_rst_start", 32'(pif.state), 1);
    chk("post_rst_ld", 32'(pif.ball_load), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
